pos_scan: RTL and testbench

Self-checking truth-table sequencer for the 4-input product-of-sums lab function `f = (b+d)(a'+b'+c)`. On `start` it drives all 16 `{a,b,c,d}` input combinations, in ascending order, into the combinational function under test. It samples the returned `f` for each combination into a 16-bit truth-table register and counts mismatches against a parameterised expected table. It sits directly upstream (stimulus) and downstream (capture) of the POS function on the lab board or bench, and replaces the hand-written `#5` stimulus list.

---
 rtl/pos_scan_if.sv | 25 ++
 rtl/pos_scan.sv | 84 ++++++++
 tb/tb_pos_scan.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pos_scan_if.sv
// Stimulus/capture bus between the truth-table sequencer and the
// POS function under test.
interface pos_scan_if;
    logic        start;
    logic        f_in;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] table_out;
    logic [4:0]  mismatch_cnt;

    modport master (
        output start, f_in,
        input  a, b, c, d, busy, done, pass, table_out, mismatch_cnt
    );

    modport slave (
        input  start, f_in,
        output a, b, c, d, busy, done, pass, table_out, mismatch_cnt
    );
endinterface

// File: rtl/pos_scan.sv
// Truth-table sequencer: walks all 16 {a,b,c,d} vectors, captures f
// for each one and counts differences against an expected table.
module pos_scan #(
    parameter int          SETTLE = 1,
    parameter logic [15:0] EXPECT = 16'hCAFA
) (
    input logic       clk,
    input logic       rst_n,
    pos_scan_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [15:0] tab_q, tab_d;
    logic [4:0]  mc_q, mc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wcnt_q  <= '0;
            tab_q   <= '0;
            mc_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            tab_q   <= tab_d;
            mc_q    <= mc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        tab_d   = tab_q;
        mc_d    = mc_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    wcnt_d  = '0;
                    tab_d   = '0;
                    mc_d    = '0;
                end
            end
            RUN: begin
                if (wcnt_q == SETTLE_C) begin
                    tab_d[idx_q] = bus.f_in;
                    if (bus.f_in != EXPECT[idx_q])
                        mc_d = mc_q + 5'd1;
                    wcnt_d = '0;
                    // index 15 ends the scan rather than wrapping
                    if (idx_q == 4'd15)
                        state_d = DONE;
                    else
                        idx_d = idx_q + 4'd1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic [3:0] abcd;

    assign abcd = (state_q == RUN) ? idx_q : 4'd0;

    assign {bus.a, bus.b, bus.c, bus.d} = abcd;
    assign bus.busy         = (state_q == RUN);
    assign bus.done         = (state_q == DONE);
    assign bus.pass         = (state_q == DONE) && (mc_q == 5'd0);
    assign bus.table_out    = tab_q;
    assign bus.mismatch_cnt = mc_q;

endmodule

// File: tb/tb_pos_scan.sv
// Bench for pos_scan: golden, stuck-at and random response tables
// on SETTLE=1 and SETTLE=0 instances.
module tb_pos_scan;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pos_scan_if if0 ();
    pos_scan_if if1 ();

    pos_scan #(.SETTLE(1), .EXPECT(16'hCAFA)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    pos_scan #(.SETTLE(0), .EXPECT(16'hCAFA)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [1:0]  start_r;
    logic        use_tbl;
    logic [15:0] resp;

    function automatic logic fref(input logic [3:0] v, input logic t,
                                  input logic [15:0] r);
        logic a, b, c, d;
        {a, b, c, d} = v;
        if (t)
            return r[v];
        return (b | d) & (~a | ~b | c);
    endfunction

    assign if0.start = start_r[0];
    assign if1.start = start_r[1];
    assign if0.f_in  = fref({if0.a, if0.b, if0.c, if0.d}, use_tbl, resp);
    assign if1.f_in  = fref({if1.a, if1.b, if1.c, if1.d}, use_tbl, resp);

    logic [1:0]  busy_w, done_w, pass_w;
    logic [3:0]  abcd_w [2];
    logic [15:0] tab_w  [2];
    logic [4:0]  mc_w   [2];

    always_comb begin
        busy_w    = {if1.busy, if0.busy};
        done_w    = {if1.done, if0.done};
        pass_w    = {if1.pass, if0.pass};
        abcd_w[0] = {if0.a, if0.b, if0.c, if0.d};
        abcd_w[1] = {if1.a, if1.b, if1.c, if1.d};
        tab_w[0]  = if0.table_out;
        tab_w[1]  = if1.table_out;
        mc_w[0]   = if0.mismatch_cnt;
        mc_w[1]   = if1.mismatch_cnt;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input int inst, input string tag);
        chk({tag, "_busy"}, busy_w[inst], 0);
        chk({tag, "_done"}, done_w[inst], 0);
        chk({tag, "_pass"}, pass_w[inst], 0);
        chk({tag, "_abcd"}, abcd_w[inst], 0);
        chk({tag, "_tab"},  tab_w[inst], 0);
        chk({tag, "_mc"},   mc_w[inst], 0);
    endtask

    // Model: vector k is held for s1 cycles; after m cycles the low
    // m/s1 table bits are captured and the count is their diff popcount.
    task automatic run_scan(input int inst, input logic [15:0] exp_tab,
                            input int pulse_at);
        int          s1;
        int          n;
        int          cyc;
        logic [16:0] mask;
        logic [15:0] diff;
        s1   = (inst == 0) ? 2 : 1;
        n    = 16 * s1;
        diff = exp_tab ^ 16'hCAFA;
        start_r[inst] = 1'b1;
        @(posedge clk);
        #1;
        start_r[inst] = 1'b0;
        cyc = 0;
        while (!done_w[inst] && cyc <= n + 8) begin
            mask = (17'd1 << (cyc / s1)) - 17'd1;
            chk("run_busy", busy_w[inst], 1);
            chk("run_done", done_w[inst], 0);
            chk("run_abcd", abcd_w[inst], 32'(cyc / s1));
            chk("run_tab",  tab_w[inst], exp_tab & mask[15:0]);
            chk("run_mc",   mc_w[inst], $countones(diff & mask[15:0]));
            start_r[inst] = (cyc == pulse_at);
            @(posedge clk);
            #1;
            cyc++;
        end
        start_r[inst] = 1'b0;
        chk("done_cycles", cyc, n);
        chk("end_busy", busy_w[inst], 0);
        chk("end_abcd", abcd_w[inst], 0);
        chk("end_tab",  tab_w[inst], exp_tab);
        chk("end_mc",   mc_w[inst], $countones(diff));
        chk("end_pass", pass_w[inst], (diff == 16'd0));
    endtask

    initial begin
        rst_n   = 1'b0;
        start_r = 2'b00;
        use_tbl = 1'b0;
        resp    = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0, "rst0");
        chk_zero(1, "rst1");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk_zero(0, "idle0");
        chk_zero(1, "idle1");

        run_scan(0, 16'hCAFA, -1);

        use_tbl = 1'b1;
        resp    = 16'h0000;
        run_scan(0, 16'h0000, -1);
        chk("stuck0_mc", mc_w[0], 10);
        resp = 16'hFFFF;
        run_scan(0, 16'hFFFF, -1);
        chk("stuck1_mc", mc_w[0], 6);

        use_tbl = 1'b0;
        run_scan(0, 16'hCAFA, 8);
        run_scan(0, 16'hCAFA, -1);

        use_tbl = 1'b1;
        for (int r = 0; r < 4; r++) begin
            resp = 16'($urandom);
            run_scan(0, resp, -1);
        end
        for (int r = 0; r < 2; r++) begin
            resp = 16'($urandom);
            run_scan(1, resp, -1);
        end

        use_tbl    = 1'b0;
        start_r[0] = 1'b1;
        @(posedge clk);
        #1;
        start_r[0] = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero(0, "midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_zero(0, "postrst");
        run_scan(0, 16'hCAFA, -1);

        run_scan(1, 16'hCAFA, -1);
        run_scan(1, 16'hCAFA, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
